// File: rtl/ddr_deser_pkg.sv
// ddr_deser_pkg: shared types and defaults for the DDR input deserializer.
package ddr_deser_pkg;

   localparam int unsigned DEF_WIDTH        = 8;
   localparam logic [7:0]  DEF_SYNC_PATTERN = 8'h1B;

   // Auto-align FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HUNT    = 2'd1,
      DISCARD = 2'd2,
      LOCKED  = 2'd3
   } align_state_t;

endpackage

// File: rtl/ddr_deser_if.sv
// ddr_deser_if: sample-pair/control inputs and word outputs of ddr_deser.
interface ddr_deser_if
   import ddr_deser_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   logic             ce;
   logic             din_0;
   logic             din_1;
   logic             bitslip;
   logic             train;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             aligned;

   modport master (
      output ce, din_0, din_1, bitslip, train,
      input  dout, dout_valid, aligned
   );

   modport slave (
      input  ce, din_0, din_1, bitslip, train,
      output dout, dout_valid, aligned
   );

endinterface

// File: rtl/ddr_deser_align.sv
// ddr_deser_align: training-word hunt FSM that steps the word boundary
// one bit per miss until the emitted word equals SYNC_PATTERN.
// Only built when DDR_DESER_ALIGN_EN is defined.
`ifdef DDR_DESER_ALIGN_EN
module ddr_deser_align
   import ddr_deser_pkg::*;
#(
   parameter int unsigned      WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEF_SYNC_PATTERN)
) (
   input  logic             clk_in,
   input  logic             resetn,
   input  logic             ce,
   input  logic             emit,
   input  logic [WIDTH-1:0] dout,
   input  logic             train,
   output logic             slip_req,
   output logic             ext_block_c,
   output logic             aligned
);

   align_state_t state;

   // Hunt/discard/lock sequencing; a miss requests one slip on the next edge
   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         slip_req <= 1'b0;
         aligned  <= 1'b0;
      end else if (ce) begin
         slip_req <= 1'b0;
         case (state)
            IDLE: begin
               if (train) state <= HUNT;
            end
            HUNT: begin
               if (emit) begin
                  if (dout == SYNC_PATTERN) begin
                     state   <= LOCKED;
                     aligned <= 1'b1;
                  end else begin
                     state    <= DISCARD;
                     slip_req <= 1'b1;
                  end
               end
            end
            DISCARD: begin
               // word straddling the slip is not trusted
               if (emit) state <= HUNT;
            end
            LOCKED: begin
               if (train) begin
                  state   <= HUNT;
                  aligned <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               aligned <= 1'b0;
            end
         endcase
      end
   end

   // External bitslip would fight the hunt, so it is masked while hunting
   assign ext_block_c = (state == HUNT) || (state == DISCARD);

endmodule
`endif

// File: rtl/ddr_deser.sv
// ddr_deser: assembles SB_IO DDR sample pairs (din_0 first, din_1 second)
// into WIDTH-bit words, MSB = earliest bit, with bitslip word alignment.
// Define DDR_DESER_ALIGN_EN to add the SYNC_PATTERN auto-aligner.
module ddr_deser
   import ddr_deser_pkg::*;
#(
   parameter int unsigned      WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(DEF_SYNC_PATTERN)
) (
   input  logic       clk_in,
   input  logic       resetn,
   ddr_deser_if.slave bus
);

   localparam int unsigned      HALF     = WIDTH / 2;
   localparam int unsigned      CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

   logic [WIDTH+1:0] hist;
   logic [CNT_W-1:0] cnt;
   logic             p;
   logic             emit_pend;
   logic [WIDTH-1:0] dout_q;
   logic             dout_valid_q;
   logic             aligned_q;
   logic [WIDTH-1:0] window_c;
   logic             emit_c;
   logic             slip_c;

   // Word window: p=1 reaches one bit further back in history
   assign window_c = p ? hist[WIDTH:1] : hist[WIDTH-1:0];

   // Emission fires on the ce edge after the last pair of a word
   assign emit_c = bus.ce & emit_pend;

`ifdef DDR_DESER_ALIGN_EN
   logic slip_req;
   logic ext_block_c;
   logic unused_c;

   ddr_deser_align #(
      .WIDTH        (WIDTH),
      .SYNC_PATTERN (SYNC_PATTERN)
   ) u_align (
      .clk_in      (clk_in),
      .resetn      (resetn),
      .ce          (bus.ce),
      .emit        (emit_c),
      .dout        (window_c),
      .train       (bus.train),
      .slip_req    (slip_req),
      .ext_block_c (ext_block_c),
      .aligned     (aligned_q)
   );

   // Slip sources: external pulse (unless hunting) or aligner request
   assign slip_c   = bus.ce & ((bus.bitslip & ~ext_block_c) | slip_req);
   assign unused_c = hist[WIDTH+1];
`else
   logic unused_c;

   assign slip_c    = bus.ce & bus.bitslip;
   assign aligned_q = 1'b0;
   assign unused_c  = ^{hist[WIDTH+1], bus.train, SYNC_PATTERN};
`endif

   // Shift history, count pairs, apply slips and emit words
   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         hist         <= '0;
         cnt          <= '0;
         p            <= 1'b0;
         emit_pend    <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         dout_valid_q <= 1'b0;
         if (bus.ce) begin
            hist <= {hist[WIDTH-1:0], bus.din_0, bus.din_1};
            // emission always uses the pre-slip window
            if (emit_pend) begin
               dout_q       <= window_c;
               dout_valid_q <= 1'b1;
            end
            if (slip_c && !p) begin
               // widen the window by one bit and stretch this word by a pair
               p         <= 1'b1;
               emit_pend <= 1'b0;
            end else begin
               if (slip_c) p <= 1'b0;
               cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
               emit_pend <= (cnt == CNT_LAST);
            end
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.aligned    = aligned_q;

endmodule

// File: tb/tb_ddr_deser.sv
// tb_ddr_deser: directed bench for ddr_deser (WIDTH=8) with a word scoreboard.
`timescale 1ns/1ps
module tb_ddr_deser;

   localparam int unsigned W = 8;

   logic clk_in = 1'b0;
   logic resetn;

   always #5 clk_in = ~clk_in;

   ddr_deser_if #(.WIDTH(W)) bus ();

   ddr_deser #(
      .WIDTH        (W),
      .SYNC_PATTERN (8'h1B)
   ) dut (
      .clk_in (clk_in),
      .resetn (resetn),
      .bus    (bus)
   );

   int         n_pass  = 0;
   int         n_fail  = 0;
   int         n_total = 0;
   logic [7:0] sb[$];
   logic [7:0] pat;
   int         ph;
   int         edge_n  = 0;
   bit         sb_on;
   bit         strobe_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive the current pair, step the stream on ce edges, score strobes
   task automatic tick();
      logic [7:0] pv;
      logic [2:0] i0;
      logic [2:0] i1;
      pv = pat;
      i0 = 3'(7 - 2 * ph);
      i1 = 3'(6 - 2 * ph);
      bus.din_0 = pv[i0];
      bus.din_1 = pv[i1];
      @(posedge clk_in);
      if (bus.ce === 1'b1 && resetn === 1'b1) ph = (ph + 1) % 4;
      #1;
      edge_n++;
      strobe_seen = (bus.dout_valid === 1'b1);
      if (strobe_seen && sb_on) begin
         check("strobe_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) check("dout", 32'(bus.dout), 32'(sb.pop_front()));
      end
   endtask

   task automatic wait_strobe(output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (strobe_seen) begin
            at = edge_n;
            break;
         end
      end
      check("strobe_timeout", 32'(at >= 0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         e;
      int         prev;
      int         base;
      logic [7:0] rot_tbl [0:8];
      rot_tbl = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};

      resetn      = 1'b0;
      bus.ce      = 1'b0;
      bus.din_0   = 1'b0;
      bus.din_1   = 1'b0;
      bus.bitslip = 1'b0;
      bus.train   = 1'b0;
      pat         = 8'hA5;
      ph          = 0;
      sb_on       = 1'b1;
      tick();
      tick();
      check("rst_dout", 32'(bus.dout), 32'h0);
      check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
      check("rst_aligned", 32'(bus.aligned), 32'h0);

      // release and stream 0xA5
      resetn = 1'b1;
      bus.ce = 1'b1;
      base   = edge_n;
      sb.push_back(8'hA5);
      wait_strobe(e);
      check("first_latency", 32'(e - base), 32'd5);
      prev = e;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(8'hA5);
         wait_strobe(e);
         check("word_spacing", 32'(e - prev), 32'd4);
         prev = e;
      end

      // eight single slips walk through every rotation and back
      for (int s = 1; s <= 8; s++) begin
         bus.bitslip = 1'b1;
         tick();
         bus.bitslip = 1'b0;
         sb.push_back(rot_tbl[s]);
         wait_strobe(e);
         check("slip_gap", 32'(e - prev), (s % 2 == 1) ? 32'd5 : 32'd4);
         prev = e;
      end

      // ce low mid-word
      sb.push_back(8'hA5);
      tick();
      bus.ce = 1'b0;
      repeat (3) begin
         tick();
         check("hold_no_strobe", 32'(strobe_seen), 32'd0);
      end
      bus.ce = 1'b1;
      wait_strobe(e);
      check("hold_gap_mid", 32'(e - prev), 32'd7);
      prev = e;

      // ce low while an emission is pending
      sb.push_back(8'hA5);
      repeat (3) tick();
      bus.ce = 1'b0;
      repeat (3) begin
         tick();
         check("pend_no_strobe", 32'(strobe_seen), 32'd0);
      end
      bus.ce = 1'b1;
      wait_strobe(e);
      check("hold_gap_pend", 32'(e - prev), 32'd7);
      prev = e;

      // asynchronous reset mid-word
      tick();
      tick();
      resetn = 1'b0;
      #1;
      check("async_rst_dout", 32'(bus.dout), 32'h0);
      check("async_rst_valid", 32'(bus.dout_valid), 32'h0);
      ph = 0;
      tick();
      resetn = 1'b1;
      base   = edge_n;
      sb.push_back(8'hA5);
      wait_strobe(e);
      check("post_rst_latency", 32'(e - base), 32'd5);
      prev = e;

`ifdef DDR_DESER_ALIGN_EN
      // auto-align to 0x1B from a stream rotated by 3 bits
      sb_on = 1'b0;
      pat   = 8'hD8;
      repeat (8) tick();
      bus.train = 1'b1;
      tick();
      bus.train = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (bus.aligned === 1'b1) break;
         tick();
      end
      check("lock_reached", 32'(bus.aligned), 32'd1);
      prev  = edge_n;
      sb_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(8'h1B);
         wait_strobe(e);
         check("locked_spacing", 32'(e - prev), 32'd4);
         check("locked_aligned", 32'(bus.aligned), 32'd1);
         prev = e;
      end

      // retrain on a correct stream re-locks on the first word
      bus.train = 1'b1;
      tick();
      bus.train = 1'b0;
      check("retrain_hunt", 32'(bus.aligned), 32'd0);
      sb.push_back(8'h1B);
      wait_strobe(e);
      check("relock_aligned", 32'(bus.aligned), 32'd1);
      check("relock_spacing", 32'(e - prev), 32'd4);
      prev = e;
`else
      // train has no effect without the aligner
      bus.train = 1'b1;
      tick();
      bus.train = 1'b0;
      check("train_ignored", 32'(bus.aligned), 32'd0);
      for (int i = 0; i < 2; i++) begin
         sb.push_back(8'hA5);
         wait_strobe(e);
         check("no_align_spacing", 32'(e - prev), 32'd4);
         check("no_align_aligned", 32'(bus.aligned), 32'd0);
         prev = e;
      end
`endif

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
